// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port framebuffer RAM between display fetch (strict priority) and CPU bus.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4800,
  parameter int STARVE_MAX = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_busy,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_err,
  output logic              o_cpu_starved,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [2:0] {C_IDLE, C_PEND, C_RD1, C_RD2, C_ACK} cstate_t;
  cstate_t state, state_n;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CW-1:0]     cnt;
  logic              ram_disp, rd_disp, oor, free;
  assign oor        = cmd_addr >= ADDR_W'(DEPTH);
  // CPU gets the RAM slot only when the display leaves it unused this cycle
  assign free       = state == C_PEND && !oor && !i_disp_req;
  assign o_cpu_busy = state != C_IDLE;
  assign o_cpu_ack  = state == C_ACK;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= C_IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      C_IDLE:  state_n = i_cpu_req ? C_PEND : C_IDLE;
      C_PEND:  state_n = oor ? C_ACK : i_disp_req ? C_PEND : cmd_we ? C_ACK : C_RD1;
      C_RD1:   state_n = C_RD2;
      C_RD2:   state_n = C_ACK;
      default: state_n = C_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      ram_disp      <= 1'b0;
      rd_disp       <= 1'b0;
      o_disp_valid  <= 1'b0;
      o_disp_data   <= '0;
      o_ram_en      <= 1'b0;
      o_ram_we      <= 1'b0;
      o_ram_addr    <= '0;
      o_ram_wdata   <= '0;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      o_cpu_rdata   <= '0;
      o_cpu_err     <= 1'b0;
      o_cpu_starved <= 1'b0;
      cnt           <= '0;
    end else begin
      ram_disp     <= i_disp_req;
      rd_disp      <= ram_disp;
      o_disp_valid <= rd_disp;
      if (rd_disp) o_disp_data <= i_ram_rdata;
      o_ram_en <= i_disp_req || free;
      o_ram_we <= free && cmd_we;
      if (i_disp_req) o_ram_addr <= i_disp_addr;
      else if (free) begin
        o_ram_addr  <= cmd_addr;
        o_ram_wdata <= cmd_wdata;
      end
      if (state == C_IDLE && i_cpu_req) begin
        cmd_we    <= i_cpu_we;
        cmd_addr  <= i_cpu_addr;
        cmd_wdata <= i_cpu_wdata;
      end
      if (state == C_PEND && oor) begin
        o_cpu_err <= 1'b1;
        if (!cmd_we) o_cpu_rdata <= '0;
      end else if (free && cmd_we) o_cpu_err <= 1'b0;
      if (state == C_RD2) begin
        o_cpu_rdata <= i_ram_rdata;
        o_cpu_err   <= 1'b0;
      end
      cnt <= state == C_PEND ? (cnt == CW'(STARVE_MAX) ? cnt : cnt + 1'b1) : '0;
      if (state == C_PEND && cnt == CW'(STARVE_MAX - 1)) o_cpu_starved <= 1'b1;
    end
endmodule
